// File: rtl/emulib_rammodel_arbiter_pkg.sv
// Shared types and helpers for the 2:1 rammodel AXI4 arbiter.
package emulib_rammodel_arbiter_pkg;

  // Width of the port-select bit prepended to master IDs on the slave side.
  localparam int unsigned PortSelW = 1;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } arb_state_e;

  // Round-robin pointer breaks ties; otherwise the lone requester wins.
  function automatic logic pick_port(input logic req0, input logic req1, input logic rr);
    if (req0 && req1) begin
      return rr;
    end
    return req1;
  endfunction

endpackage

// File: rtl/emulib_rammodel_addr_arb.sv
// Round-robin IDLE/BUSY arbiter and mux for one AXI4 address channel (AW or AR).
module emulib_rammodel_addr_arb
  import emulib_rammodel_arbiter_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned IdWidth   = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        can_grant_i,
  input  logic                        s0_valid_i,
  input  logic [AddrWidth-1:0]        s0_addr_i,
  input  logic [IdWidth-1:0]          s0_id_i,
  input  logic [7:0]                  s0_len_i,
  input  logic [2:0]                  s0_size_i,
  input  logic [1:0]                  s0_burst_i,
  output logic                        s0_ready_o,
  input  logic                        s1_valid_i,
  input  logic [AddrWidth-1:0]        s1_addr_i,
  input  logic [IdWidth-1:0]          s1_id_i,
  input  logic [7:0]                  s1_len_i,
  input  logic [2:0]                  s1_size_i,
  input  logic [1:0]                  s1_burst_i,
  output logic                        s1_ready_o,
  output logic                        m_valid_o,
  output logic [AddrWidth-1:0]        m_addr_o,
  output logic [IdWidth+PortSelW-1:0] m_id_o,
  output logic [7:0]                  m_len_o,
  output logic [2:0]                  m_size_o,
  output logic [1:0]                  m_burst_o,
  input  logic                        m_ready_i
);

  arb_state_e state_q, state_d;
  logic       grant_q, grant_d;
  logic       rr_q, rr_d;
  logic       busy;

  // Forward the granted port; the grant is registered so nothing handshakes in IDLE.
  always_comb begin
    busy       = (state_q == StBusy);
    m_valid_o  = busy && (grant_q ? s1_valid_i : s0_valid_i);
    m_addr_o   = grant_q ? s1_addr_i : s0_addr_i;
    m_id_o     = {grant_q, (grant_q ? s1_id_i : s0_id_i)};
    m_len_o    = grant_q ? s1_len_i : s0_len_i;
    m_size_o   = grant_q ? s1_size_i : s0_size_i;
    m_burst_o  = grant_q ? s1_burst_i : s0_burst_i;
    s0_ready_o = busy && !grant_q && m_ready_i;
    s1_ready_o = busy && grant_q && m_ready_i;
  end

  // Next-state: take a grant in IDLE, release it and flip priority on handshake.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    unique case (state_q)
      StIdle: begin
        if ((s0_valid_i || s1_valid_i) && can_grant_i) begin
          grant_d = pick_port(s0_valid_i, s1_valid_i, rr_q);
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (m_valid_o && m_ready_i) begin
          rr_d    = ~grant_q;
          state_d = StIdle;
        end
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      grant_q <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

endmodule

// File: rtl/emulib_rammodel_arbiter.sv
// 2:1 AXI4 arbiter in front of the rammodel slave port; port number rides in the ID MSB.
module emulib_rammodel_arbiter
  import emulib_rammodel_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned ID_WIDTH    = 4,
  parameter int unsigned WFIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  // Master 0
  input  logic [ADDR_WIDTH-1:0]        s0_axi_awaddr,
  input  logic [ID_WIDTH-1:0]          s0_axi_awid,
  input  logic [7:0]                   s0_axi_awlen,
  input  logic [2:0]                   s0_axi_awsize,
  input  logic [1:0]                   s0_axi_awburst,
  input  logic                         s0_axi_awvalid,
  output logic                         s0_axi_awready,
  input  logic [DATA_WIDTH-1:0]        s0_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]      s0_axi_wstrb,
  input  logic                         s0_axi_wlast,
  input  logic                         s0_axi_wvalid,
  output logic                         s0_axi_wready,
  output logic [ID_WIDTH-1:0]          s0_axi_bid,
  output logic [1:0]                   s0_axi_bresp,
  output logic                         s0_axi_bvalid,
  input  logic                         s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0]        s0_axi_araddr,
  input  logic [ID_WIDTH-1:0]          s0_axi_arid,
  input  logic [7:0]                   s0_axi_arlen,
  input  logic [2:0]                   s0_axi_arsize,
  input  logic [1:0]                   s0_axi_arburst,
  input  logic                         s0_axi_arvalid,
  output logic                         s0_axi_arready,
  output logic [ID_WIDTH-1:0]          s0_axi_rid,
  output logic [DATA_WIDTH-1:0]        s0_axi_rdata,
  output logic [1:0]                   s0_axi_rresp,
  output logic                         s0_axi_rlast,
  output logic                         s0_axi_rvalid,
  input  logic                         s0_axi_rready,
  // Master 1
  input  logic [ADDR_WIDTH-1:0]        s1_axi_awaddr,
  input  logic [ID_WIDTH-1:0]          s1_axi_awid,
  input  logic [7:0]                   s1_axi_awlen,
  input  logic [2:0]                   s1_axi_awsize,
  input  logic [1:0]                   s1_axi_awburst,
  input  logic                         s1_axi_awvalid,
  output logic                         s1_axi_awready,
  input  logic [DATA_WIDTH-1:0]        s1_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]      s1_axi_wstrb,
  input  logic                         s1_axi_wlast,
  input  logic                         s1_axi_wvalid,
  output logic                         s1_axi_wready,
  output logic [ID_WIDTH-1:0]          s1_axi_bid,
  output logic [1:0]                   s1_axi_bresp,
  output logic                         s1_axi_bvalid,
  input  logic                         s1_axi_bready,
  input  logic [ADDR_WIDTH-1:0]        s1_axi_araddr,
  input  logic [ID_WIDTH-1:0]          s1_axi_arid,
  input  logic [7:0]                   s1_axi_arlen,
  input  logic [2:0]                   s1_axi_arsize,
  input  logic [1:0]                   s1_axi_arburst,
  input  logic                         s1_axi_arvalid,
  output logic                         s1_axi_arready,
  output logic [ID_WIDTH-1:0]          s1_axi_rid,
  output logic [DATA_WIDTH-1:0]        s1_axi_rdata,
  output logic [1:0]                   s1_axi_rresp,
  output logic                         s1_axi_rlast,
  output logic                         s1_axi_rvalid,
  input  logic                         s1_axi_rready,
  // To the rammodel
  output logic [ADDR_WIDTH-1:0]        m_axi_awaddr,
  output logic [ID_WIDTH+PortSelW-1:0] m_axi_awid,
  output logic [7:0]                   m_axi_awlen,
  output logic [2:0]                   m_axi_awsize,
  output logic [1:0]                   m_axi_awburst,
  output logic                         m_axi_awvalid,
  input  logic                         m_axi_awready,
  output logic [DATA_WIDTH-1:0]        m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]      m_axi_wstrb,
  output logic                         m_axi_wlast,
  output logic                         m_axi_wvalid,
  input  logic                         m_axi_wready,
  input  logic [ID_WIDTH+PortSelW-1:0] m_axi_bid,
  input  logic [1:0]                   m_axi_bresp,
  input  logic                         m_axi_bvalid,
  output logic                         m_axi_bready,
  output logic [ADDR_WIDTH-1:0]        m_axi_araddr,
  output logic [ID_WIDTH+PortSelW-1:0] m_axi_arid,
  output logic [7:0]                   m_axi_arlen,
  output logic [2:0]                   m_axi_arsize,
  output logic [1:0]                   m_axi_arburst,
  output logic                         m_axi_arvalid,
  input  logic                         m_axi_arready,
  input  logic [ID_WIDTH+PortSelW-1:0] m_axi_rid,
  input  logic [DATA_WIDTH-1:0]        m_axi_rdata,
  input  logic [1:0]                   m_axi_rresp,
  input  logic                         m_axi_rlast,
  input  logic                         m_axi_rvalid,
  output logic                         m_axi_rready
);

  localparam int unsigned PtrW = $clog2(WFIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WFIFO_DEPTH-1:0] wfifo_q, wfifo_d;
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        count_q, count_d;
  logic                   full, empty, head, push, pop, bsel, rsel;

  // Full uses the registered count, so a same-cycle pop never enables a grant.
  assign full = (count_q == CntW'(WFIFO_DEPTH));

  emulib_rammodel_addr_arb #(
    .AddrWidth(ADDR_WIDTH),
    .IdWidth  (ID_WIDTH)
  ) u_aw_arb (
    .clk_i      (clk),
    .rst_i      (rst),
    .can_grant_i(!full),
    .s0_valid_i (s0_axi_awvalid),
    .s0_addr_i  (s0_axi_awaddr),
    .s0_id_i    (s0_axi_awid),
    .s0_len_i   (s0_axi_awlen),
    .s0_size_i  (s0_axi_awsize),
    .s0_burst_i (s0_axi_awburst),
    .s0_ready_o (s0_axi_awready),
    .s1_valid_i (s1_axi_awvalid),
    .s1_addr_i  (s1_axi_awaddr),
    .s1_id_i    (s1_axi_awid),
    .s1_len_i   (s1_axi_awlen),
    .s1_size_i  (s1_axi_awsize),
    .s1_burst_i (s1_axi_awburst),
    .s1_ready_o (s1_axi_awready),
    .m_valid_o  (m_axi_awvalid),
    .m_addr_o   (m_axi_awaddr),
    .m_id_o     (m_axi_awid),
    .m_len_o    (m_axi_awlen),
    .m_size_o   (m_axi_awsize),
    .m_burst_o  (m_axi_awburst),
    .m_ready_i  (m_axi_awready)
  );

  emulib_rammodel_addr_arb #(
    .AddrWidth(ADDR_WIDTH),
    .IdWidth  (ID_WIDTH)
  ) u_ar_arb (
    .clk_i      (clk),
    .rst_i      (rst),
    .can_grant_i(1'b1),
    .s0_valid_i (s0_axi_arvalid),
    .s0_addr_i  (s0_axi_araddr),
    .s0_id_i    (s0_axi_arid),
    .s0_len_i   (s0_axi_arlen),
    .s0_size_i  (s0_axi_arsize),
    .s0_burst_i (s0_axi_arburst),
    .s0_ready_o (s0_axi_arready),
    .s1_valid_i (s1_axi_arvalid),
    .s1_addr_i  (s1_axi_araddr),
    .s1_id_i    (s1_axi_arid),
    .s1_len_i   (s1_axi_arlen),
    .s1_size_i  (s1_axi_arsize),
    .s1_burst_i (s1_axi_arburst),
    .s1_ready_o (s1_axi_arready),
    .m_valid_o  (m_axi_arvalid),
    .m_addr_o   (m_axi_araddr),
    .m_id_o     (m_axi_arid),
    .m_len_o    (m_axi_arlen),
    .m_size_o   (m_axi_arsize),
    .m_burst_o  (m_axi_arburst),
    .m_ready_i  (m_axi_arready)
  );

  // W channel follows the port at the head of the AW-order FIFO.
  always_comb begin
    empty         = (count_q == '0);
    head          = wfifo_q[rd_ptr_q];
    m_axi_wvalid  = !empty && (head ? s1_axi_wvalid : s0_axi_wvalid);
    m_axi_wdata   = head ? s1_axi_wdata : s0_axi_wdata;
    m_axi_wstrb   = head ? s1_axi_wstrb : s0_axi_wstrb;
    m_axi_wlast   = head ? s1_axi_wlast : s0_axi_wlast;
    s0_axi_wready = !empty && !head && m_axi_wready;
    s1_axi_wready = !empty && head && m_axi_wready;
    push          = m_axi_awvalid && m_axi_awready;
    pop           = m_axi_wvalid && m_axi_wready && m_axi_wlast;
  end

  // FIFO next-state: push the granted port (ID MSB) on AW handshake, pop on last W beat.
  always_comb begin
    wfifo_d  = wfifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wfifo_d[wr_ptr_q] = m_axi_awid[ID_WIDTH];
      wr_ptr_d          = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  // FIFO registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wfifo_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wfifo_q  <= wfifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Response demux keyed on the ID MSB added at address time.
  always_comb begin
    bsel          = m_axi_bid[ID_WIDTH];
    s0_axi_bvalid = m_axi_bvalid && !bsel;
    s1_axi_bvalid = m_axi_bvalid && bsel;
    s0_axi_bid    = m_axi_bid[ID_WIDTH-1:0];
    s1_axi_bid    = m_axi_bid[ID_WIDTH-1:0];
    s0_axi_bresp  = m_axi_bresp;
    s1_axi_bresp  = m_axi_bresp;
    m_axi_bready  = bsel ? s1_axi_bready : s0_axi_bready;

    rsel          = m_axi_rid[ID_WIDTH];
    s0_axi_rvalid = m_axi_rvalid && !rsel;
    s1_axi_rvalid = m_axi_rvalid && rsel;
    s0_axi_rid    = m_axi_rid[ID_WIDTH-1:0];
    s1_axi_rid    = m_axi_rid[ID_WIDTH-1:0];
    s0_axi_rdata  = m_axi_rdata;
    s1_axi_rdata  = m_axi_rdata;
    s0_axi_rresp  = m_axi_rresp;
    s1_axi_rresp  = m_axi_rresp;
    s0_axi_rlast  = m_axi_rlast;
    s1_axi_rlast  = m_axi_rlast;
    m_axi_rready  = rsel ? s1_axi_rready : s0_axi_rready;
  end

endmodule

// File: tb/tb_emulib_rammodel_arbiter.sv
// Directed bench for the 2:1 rammodel arbiter.
module tb_emulib_rammodel_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [31:0] s0_axi_awaddr, s1_axi_awaddr, s0_axi_araddr, s1_axi_araddr;
  logic [3:0]  s0_axi_awid, s1_axi_awid, s0_axi_arid, s1_axi_arid;
  logic [7:0]  s0_axi_awlen, s1_axi_awlen, s0_axi_arlen, s1_axi_arlen;
  logic [2:0]  s0_axi_awsize, s1_axi_awsize, s0_axi_arsize, s1_axi_arsize;
  logic [1:0]  s0_axi_awburst, s1_axi_awburst, s0_axi_arburst, s1_axi_arburst;
  logic        s0_axi_awvalid, s1_axi_awvalid, s0_axi_arvalid, s1_axi_arvalid;
  logic        s0_axi_awready, s1_axi_awready, s0_axi_arready, s1_axi_arready;
  logic [63:0] s0_axi_wdata, s1_axi_wdata;
  logic [7:0]  s0_axi_wstrb, s1_axi_wstrb;
  logic        s0_axi_wlast, s1_axi_wlast, s0_axi_wvalid, s1_axi_wvalid;
  logic        s0_axi_wready, s1_axi_wready;
  logic [3:0]  s0_axi_bid, s1_axi_bid, s0_axi_rid, s1_axi_rid;
  logic [1:0]  s0_axi_bresp, s1_axi_bresp, s0_axi_rresp, s1_axi_rresp;
  logic        s0_axi_bvalid, s1_axi_bvalid, s0_axi_bready, s1_axi_bready;
  logic [63:0] s0_axi_rdata, s1_axi_rdata;
  logic        s0_axi_rlast, s1_axi_rlast, s0_axi_rvalid, s1_axi_rvalid;
  logic        s0_axi_rready, s1_axi_rready;

  logic [31:0] m_axi_awaddr, m_axi_araddr;
  logic [4:0]  m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
  logic [7:0]  m_axi_awlen, m_axi_arlen;
  logic [2:0]  m_axi_awsize, m_axi_arsize;
  logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic        m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
  logic [63:0] m_axi_wdata, m_axi_rdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready, m_axi_rlast, m_axi_rvalid, m_axi_rready;

  int checks = 0;
  int passed = 0;

  // Every valid/ready the DUT drives.
  logic [14:0] vr;
  assign vr = {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready,
               s0_axi_awready, s0_axi_wready, s0_axi_arready, s0_axi_bvalid, s0_axi_rvalid,
               s1_axi_awready, s1_axi_wready, s1_axi_arready, s1_axi_bvalid, s1_axi_rvalid};

  always #5 clk = ~clk;

  emulib_rammodel_arbiter #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (64),
    .ID_WIDTH   (4),
    .WFIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .s0_axi_awaddr(s0_axi_awaddr), .s0_axi_awid(s0_axi_awid), .s0_axi_awlen(s0_axi_awlen),
    .s0_axi_awsize(s0_axi_awsize), .s0_axi_awburst(s0_axi_awburst),
    .s0_axi_awvalid(s0_axi_awvalid), .s0_axi_awready(s0_axi_awready),
    .s0_axi_wdata(s0_axi_wdata), .s0_axi_wstrb(s0_axi_wstrb), .s0_axi_wlast(s0_axi_wlast),
    .s0_axi_wvalid(s0_axi_wvalid), .s0_axi_wready(s0_axi_wready),
    .s0_axi_bid(s0_axi_bid), .s0_axi_bresp(s0_axi_bresp), .s0_axi_bvalid(s0_axi_bvalid),
    .s0_axi_bready(s0_axi_bready),
    .s0_axi_araddr(s0_axi_araddr), .s0_axi_arid(s0_axi_arid), .s0_axi_arlen(s0_axi_arlen),
    .s0_axi_arsize(s0_axi_arsize), .s0_axi_arburst(s0_axi_arburst),
    .s0_axi_arvalid(s0_axi_arvalid), .s0_axi_arready(s0_axi_arready),
    .s0_axi_rid(s0_axi_rid), .s0_axi_rdata(s0_axi_rdata), .s0_axi_rresp(s0_axi_rresp),
    .s0_axi_rlast(s0_axi_rlast), .s0_axi_rvalid(s0_axi_rvalid), .s0_axi_rready(s0_axi_rready),
    .s1_axi_awaddr(s1_axi_awaddr), .s1_axi_awid(s1_axi_awid), .s1_axi_awlen(s1_axi_awlen),
    .s1_axi_awsize(s1_axi_awsize), .s1_axi_awburst(s1_axi_awburst),
    .s1_axi_awvalid(s1_axi_awvalid), .s1_axi_awready(s1_axi_awready),
    .s1_axi_wdata(s1_axi_wdata), .s1_axi_wstrb(s1_axi_wstrb), .s1_axi_wlast(s1_axi_wlast),
    .s1_axi_wvalid(s1_axi_wvalid), .s1_axi_wready(s1_axi_wready),
    .s1_axi_bid(s1_axi_bid), .s1_axi_bresp(s1_axi_bresp), .s1_axi_bvalid(s1_axi_bvalid),
    .s1_axi_bready(s1_axi_bready),
    .s1_axi_araddr(s1_axi_araddr), .s1_axi_arid(s1_axi_arid), .s1_axi_arlen(s1_axi_arlen),
    .s1_axi_arsize(s1_axi_arsize), .s1_axi_arburst(s1_axi_arburst),
    .s1_axi_arvalid(s1_axi_arvalid), .s1_axi_arready(s1_axi_arready),
    .s1_axi_rid(s1_axi_rid), .s1_axi_rdata(s1_axi_rdata), .s1_axi_rresp(s1_axi_rresp),
    .s1_axi_rlast(s1_axi_rlast), .s1_axi_rvalid(s1_axi_rvalid), .s1_axi_rready(s1_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awid(m_axi_awid), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arid(m_axi_arid), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  task automatic clear_inputs();
    s0_axi_awaddr = '0; s0_axi_awid = '0; s0_axi_awlen = '0; s0_axi_awsize = 3'd3;
    s0_axi_awburst = 2'b01; s0_axi_awvalid = 0;
    s1_axi_awaddr = '0; s1_axi_awid = '0; s1_axi_awlen = '0; s1_axi_awsize = 3'd3;
    s1_axi_awburst = 2'b01; s1_axi_awvalid = 0;
    s0_axi_araddr = '0; s0_axi_arid = '0; s0_axi_arlen = '0; s0_axi_arsize = 3'd3;
    s0_axi_arburst = 2'b01; s0_axi_arvalid = 0;
    s1_axi_araddr = '0; s1_axi_arid = '0; s1_axi_arlen = '0; s1_axi_arsize = 3'd3;
    s1_axi_arburst = 2'b01; s1_axi_arvalid = 0;
    s0_axi_wdata = '0; s0_axi_wstrb = 8'hFF; s0_axi_wlast = 0; s0_axi_wvalid = 0;
    s1_axi_wdata = '0; s1_axi_wstrb = 8'hFF; s1_axi_wlast = 0; s1_axi_wvalid = 0;
    s0_axi_bready = 0; s1_axi_bready = 0; s0_axi_rready = 0; s1_axi_rready = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
    m_axi_bid = '0; m_axi_bresp = '0; m_axi_bvalid = 0;
    m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 0; m_axi_rvalid = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    clear_inputs();
    rst = 1;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 0;
  endtask

  // Returns at the negedge before the next AW handshake edge.
  task automatic wait_aw(output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_axi_awvalid && m_axi_awready) begin
        ok = 1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (vr !== 15'h0) $display("FAIL reset_idle[%0d]: got %h want 0", i, vr);
      else passed++;
    end
    @(posedge clk); #1;
    s1_axi_awvalid = 1; s1_axi_awaddr = 32'h100; s1_axi_awid = 4'h3; s1_axi_awlen = 8'd0;
    @(negedge clk);
    checks++;
    if (m_axi_awvalid !== 1'b0) $display("FAIL solo_aw_cycle0: got %b want 0", m_axi_awvalid);
    else passed++;
    @(negedge clk);
    checks++;
    if ({m_axi_awvalid, m_axi_awid, m_axi_awaddr} !== {1'b1, 5'h13, 32'h100})
      $display("FAIL solo_aw_cycle1: got v=%b id=%h a=%h want v=1 id=13 a=100",
               m_axi_awvalid, m_axi_awid, m_axi_awaddr);
    else passed++;
    @(posedge clk); #1;
    m_axi_awready = 1;
    @(negedge clk);
    checks++;
    if ({s1_axi_awready, s0_axi_awready} !== 2'b10)
      $display("FAIL solo_aw_ready: got %b want 10", {s1_axi_awready, s0_axi_awready});
    else passed++;
    @(posedge clk); #1;
    s1_axi_awvalid = 0; m_axi_awready = 0;
    s1_axi_wvalid = 1; s1_axi_wdata = 64'hAB; s1_axi_wlast = 1; m_axi_wready = 1;
    @(negedge clk);
    checks++;
    if ({m_axi_wvalid, s1_axi_wready, s0_axi_wready, m_axi_wdata} !== {3'b110, 64'hAB})
      $display("FAIL solo_w: got v=%b r1=%b r0=%b d=%h want 1 1 0 ab",
               m_axi_wvalid, s1_axi_wready, s0_axi_wready, m_axi_wdata);
    else passed++;
    @(posedge clk); #1;
    s1_axi_wvalid = 0; m_axi_wready = 0;
  endtask

  task automatic test_rr();
    logic [4:0] got [8];
    logic [4:0] want;
    int n = 0;
    do_reset();
    s0_axi_wvalid = 1; s0_axi_wlast = 1; s1_axi_wvalid = 1; s1_axi_wlast = 1;
    m_axi_wready = 1; m_axi_awready = 1;
    s0_axi_awid = 4'hA; s1_axi_awid = 4'h5;
    s0_axi_awvalid = 1; s1_axi_awvalid = 1;
    for (int i = 0; i < 60 && n < 8; i++) begin
      @(negedge clk);
      if (m_axi_awvalid && m_axi_awready) begin
        got[n] = m_axi_awid;
        n++;
      end
    end
    @(posedge clk); #1;
    clear_inputs();
    checks++;
    if (n !== 8) $display("FAIL rr_count: got %0d want 8", n);
    else passed++;
    for (int i = 0; i < 8; i++) begin
      want = (i % 2 == 0) ? 5'h0A : 5'h15;
      checks++;
      if (i < n && got[i] === want) passed++;
      else $display("FAIL rr_grant[%0d]: got %h want %h", i, got[i], want);
    end
  endtask

  task automatic test_w_order();
    bit ok;
    do_reset();
    m_axi_wready = 1;
    s1_axi_wvalid = 1; s1_axi_wdata = 64'hB0; s1_axi_wlast = 0;
    s0_axi_awvalid = 1; s0_axi_awaddr = 32'h80; s0_axi_awid = 4'h1; s0_axi_awlen = 8'd3;
    m_axi_awready = 1;
    wait_aw(ok);
    checks++;
    if (!ok || m_axi_awid !== 5'h01) $display("FAIL order_aw0: got %h want 01", m_axi_awid);
    else passed++;
    @(posedge clk); #1;
    s0_axi_awvalid = 0;
    s1_axi_awvalid = 1; s1_axi_awaddr = 32'h90; s1_axi_awid = 4'h2; s1_axi_awlen = 8'd1;
    wait_aw(ok);
    checks++;
    if (!ok || m_axi_awid !== 5'h12) $display("FAIL order_aw1: got %h want 12", m_axi_awid);
    else passed++;
    @(posedge clk); #1;
    s1_axi_awvalid = 0; m_axi_awready = 0;
    @(negedge clk);
    checks++;
    if ({m_axi_wvalid, s1_axi_wready} !== 2'b00)
      $display("FAIL order_s1_blocked: got %b want 00", {m_axi_wvalid, s1_axi_wready});
    else passed++;
    for (int b = 0; b < 4; b++) begin
      @(posedge clk); #1;
      s0_axi_wvalid = 1; s0_axi_wdata = 64'hA0 + 64'(b); s0_axi_wlast = (b == 3);
      @(negedge clk);
      checks++;
      if ({m_axi_wvalid, s0_axi_wready, s1_axi_wready, m_axi_wlast} !== {3'b110, (b == 3)}
          || m_axi_wdata !== 64'hA0 + 64'(b))
        $display("FAIL order_s0_beat%0d: got d=%h r0=%b r1=%b last=%b want d=%h",
                 b, m_axi_wdata, s0_axi_wready, s1_axi_wready, m_axi_wlast, 64'hA0 + 64'(b));
      else passed++;
    end
    @(posedge clk); #1;
    s0_axi_wvalid = 0;
    for (int b = 0; b < 2; b++) begin
      s1_axi_wdata = 64'hB0 + 64'(b); s1_axi_wlast = (b == 1);
      @(negedge clk);
      checks++;
      if ({m_axi_wvalid, s1_axi_wready, m_axi_wlast} !== {2'b11, (b == 1)}
          || m_axi_wdata !== 64'hB0 + 64'(b))
        $display("FAIL order_s1_beat%0d: got d=%h r1=%b want d=%h",
                 b, m_axi_wdata, s1_axi_wready, 64'hB0 + 64'(b));
      else passed++;
      @(posedge clk); #1;
    end
    s1_axi_wvalid = 0;
    s0_axi_wvalid = 1;
    @(negedge clk);
    checks++;
    if (m_axi_wvalid !== 1'b0) $display("FAIL order_drained: got %b want 0", m_axi_wvalid);
    else passed++;
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_full();
    int n = 0;
    do_reset();
    s0_axi_awvalid = 1; s0_axi_awid = 4'h1; s0_axi_awlen = 8'd0; m_axi_awready = 1;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (m_axi_awvalid && m_axi_awready) n++;
    end
    checks++;
    if (n !== 4) $display("FAIL full_grants: got %0d want 4", n);
    else passed++;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (m_axi_awvalid !== 1'b0) $display("FAIL full_blocked[%0d]: got %b want 0", i, m_axi_awvalid);
      else passed++;
    end
    @(posedge clk); #1;
    s0_axi_wvalid = 1; s0_axi_wlast = 1; m_axi_wready = 1;
    @(negedge clk);
    checks++;
    if ({m_axi_wvalid, s0_axi_wready, m_axi_awvalid} !== 3'b110)
      $display("FAIL full_pop: got %b want 110", {m_axi_wvalid, s0_axi_wready, m_axi_awvalid});
    else passed++;
    @(posedge clk); #1;
    s0_axi_wvalid = 0; m_axi_wready = 0;
    @(negedge clk);
    checks++;
    if (m_axi_awvalid !== 1'b0) $display("FAIL full_after_pop0: got %b want 0", m_axi_awvalid);
    else passed++;
    @(negedge clk);
    checks++;
    if (m_axi_awvalid !== 1'b1) $display("FAIL full_after_pop1: got %b want 1", m_axi_awvalid);
    else passed++;
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_resp();
    do_reset();
    s1_axi_rready = 1; s0_axi_rready = 0;
    m_axi_rvalid = 1; m_axi_rid = 5'h15; m_axi_rlast = 1; m_axi_rdata = 64'hDEAD; m_axi_rresp = 2'b00;
    @(negedge clk);
    checks++;
    if ({s1_axi_rvalid, s0_axi_rvalid, s1_axi_rid, s1_axi_rlast, m_axi_rready} !== {2'b10, 4'h5, 2'b11}
        || s1_axi_rdata !== 64'hDEAD)
      $display("FAIL resp_r: got v1=%b v0=%b id=%h last=%b rdy=%b d=%h want 1 0 5 1 1 dead",
               s1_axi_rvalid, s0_axi_rvalid, s1_axi_rid, s1_axi_rlast, m_axi_rready, s1_axi_rdata);
    else passed++;
    @(posedge clk); #1;
    m_axi_rvalid = 0;
    s0_axi_bready = 1; s1_axi_bready = 0;
    m_axi_bvalid = 1; m_axi_bid = 5'h02; m_axi_bresp = 2'b10;
    @(negedge clk);
    checks++;
    if ({s0_axi_bvalid, s1_axi_bvalid, s0_axi_bid, s0_axi_bresp, m_axi_bready} !== {2'b10, 4'h2, 2'b10, 1'b1})
      $display("FAIL resp_b: got v0=%b v1=%b id=%h resp=%b rdy=%b want 1 0 2 10 1",
               s0_axi_bvalid, s1_axi_bvalid, s0_axi_bid, s0_axi_bresp, m_axi_bready);
    else passed++;
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_mid_reset();
    bit ok;
    do_reset();
    s0_axi_awvalid = 1; s0_axi_awaddr = 32'h40; s0_axi_awid = 4'h1; s0_axi_awlen = 8'd3;
    m_axi_awready = 1;
    wait_aw(ok);
    @(posedge clk); #1;
    s0_axi_awvalid = 0; m_axi_awready = 0; m_axi_wready = 1;
    for (int b = 0; b < 2; b++) begin
      s0_axi_wvalid = 1; s0_axi_wdata = 64'hE0 + 64'(b); s0_axi_wlast = 0;
      @(posedge clk); #1;
    end
    clear_inputs();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    s0_axi_wvalid = 1; s0_axi_wlast = 1; s1_axi_wvalid = 1; s1_axi_wlast = 1; m_axi_wready = 1;
    @(negedge clk);
    checks++;
    if (vr !== 15'h0) $display("FAIL mid_reset_clear: got %h want 0", vr);
    else passed++;
    @(posedge clk); #1;
    clear_inputs();
    s0_axi_awvalid = 1; s0_axi_awaddr = 32'h200; s0_axi_awid = 4'h7; s0_axi_awlen = 8'd1;
    s1_axi_awvalid = 1; s1_axi_awaddr = 32'h300; s1_axi_awid = 4'h2; s1_axi_awlen = 8'd0;
    m_axi_awready = 1;
    wait_aw(ok);
    checks++;
    if (!ok || m_axi_awid !== 5'h07 || m_axi_awaddr !== 32'h200)
      $display("FAIL mid_reset_rr: got id=%h a=%h want 07 200", m_axi_awid, m_axi_awaddr);
    else passed++;
    @(posedge clk); #1;
    s0_axi_awvalid = 0;
    wait_aw(ok);
    checks++;
    if (!ok || m_axi_awid !== 5'h12) $display("FAIL mid_reset_aw1: got %h want 12", m_axi_awid);
    else passed++;
    @(posedge clk); #1;
    s1_axi_awvalid = 0; m_axi_awready = 0; m_axi_wready = 1;
    s1_axi_wvalid = 1; s1_axi_wdata = 64'hD0; s1_axi_wlast = 1;
    for (int b = 0; b < 2; b++) begin
      s0_axi_wvalid = 1; s0_axi_wdata = 64'hC0 + 64'(b); s0_axi_wlast = (b == 1);
      @(negedge clk);
      checks++;
      if (!m_axi_wvalid || !s0_axi_wready || m_axi_wdata !== 64'hC0 + 64'(b))
        $display("FAIL mid_reset_s0_beat%0d: got d=%h v=%b want %h",
                 b, m_axi_wdata, m_axi_wvalid, 64'hC0 + 64'(b));
      else passed++;
      @(posedge clk); #1;
    end
    s0_axi_wvalid = 0;
    @(negedge clk);
    checks++;
    if (!m_axi_wvalid || !s1_axi_wready || m_axi_wdata !== 64'hD0)
      $display("FAIL mid_reset_s1_beat: got d=%h r1=%b want d0 1", m_axi_wdata, s1_axi_wready);
    else passed++;
    @(posedge clk); #1;
    s1_axi_wvalid = 0; m_axi_wready = 0;
    s0_axi_bready = 1; m_axi_bvalid = 1; m_axi_bid = 5'h07;
    @(negedge clk);
    checks++;
    if ({s0_axi_bvalid, s1_axi_bvalid, s0_axi_bid} !== {2'b10, 4'h7})
      $display("FAIL mid_reset_b: got v0=%b v1=%b id=%h want 1 0 7",
               s0_axi_bvalid, s1_axi_bvalid, s0_axi_bid);
    else passed++;
    @(posedge clk); #1;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_rr();
    test_w_order();
    test_full();
    test_resp();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", passed, checks);
    $fatal(1);
  end

endmodule

// File: doc/emulib_rammodel_arbiter.md
Name: emulib_rammodel_arbiter

Overview:
- 2:1 AXI4 arbiter that shares one rammodel slave port (ID width ID_WIDTH+1) between two AXI4 masters, e.g. a DUT core and a DMA/loader.
- Independent round-robin arbitration on AW and AR.
- Write-data ordering is tracked by a port-order FIFO.
- Responses are routed back by the extra ID MSB.
- Sits directly in front of the rammodel's s_axi port.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 64, data width of all ports (8/16/32/64).
- ID_WIDTH, 4, master-side ID width; the slave-side ID is ID_WIDTH+1.
- WFIFO_DEPTH, 4, outstanding AW grants whose W bursts are not yet complete; power of 2, >=2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- s0_axi_*  -  AXI4 slave bundle  master 0. Address channels carry {addr,id,len,size,burst}, W carries {data,strb,last}, B/R return id.
- s1_axi_*  -  AXI4 slave bundle  master 1, same widths as s0.
- m_axi_*  -  AXI4 master bundle  to the rammodel. IDs are ID_WIDTH+1 bits, {port, id}; all other widths match s0.
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.

Behaviour:
- Reset values:
  - All m_*valid, m_*ready, s*_*valid and s*_*ready are 0.
  - AW and AR FSMs are IDLE.
  - Both RR pointers are 0, so port 0 wins first.
  - WFIFO is empty, count 0.
- AW FSM, states IDLE and BUSY:
  - IDLE: if any s*_awvalid and WFIFO count < WFIFO_DEPTH, register grant g. If both are valid, g = rr_aw; otherwise g is the single valid port. Go to BUSY. No handshake happens in IDLE.
  - BUSY: m_awvalid = s[g]_awvalid. The payload is s[g]'s, with m_awid = {g, s[g]_awid}. s[g]_awready = m_awready; the other port's awready is 0.
  - On m_awvalid&&m_awready: push g into WFIFO, set rr_aw = ~g, return to IDLE.
  - Minimum is 2 cycles per AW grant. AXI valid stability guarantees s[g]_awvalid holds in BUSY.
- AR FSM: identical to AW, using rr_ar and m_arid = {g, s[g]_arid}. There is no FIFO condition.
- W routing:
  - WFIFO empty: m_wvalid = 0 and both s*_wready = 0.
  - Otherwise, with h = FIFO head: m_w* = s[h]_w*, s[h]_wready = m_wready, the other wready = 0.
  - Pop on m_wvalid&&m_wready&&m_wlast.
  - W beats for an AW are never forwarded in the same cycle as that AW handshake. The push is registered, so data flows from the next cycle.
  - Push and pop in the same cycle leave the count unchanged; both pointers advance.
  - Full is evaluated on the registered count, so no grant is taken while full, even if a pop happens that cycle.
- B demux (combinational), with p = m_bid[ID_WIDTH]:
  - s[p]_bvalid = m_bvalid; s[p]_bid = m_bid[ID_WIDTH-1:0]; m_bready = s[p]_bready.
  - The other port's bvalid = 0.
- R demux: same scheme keyed on m_rid[ID_WIDTH]. rdata and rlast pass through unchanged.
- Throughput:
  - AW and AR are fully independent.
  - Multiple bursts may be outstanding per port.
  - Response ordering per port follows rammodel ordering per ID.
- Reset mid-operation: all state is cleared and in-flight transactions are dropped. Masters and rammodel must be reset in the same cycle.
- No error responses are generated; bresp/rresp pass through.

Decomposition:
- Shared header, alongside the existing AXI macro headers: the port-select width constant (1), and the AXI4 port-list/connect macros reused for the s0/s1/m bundles.
- Sub-module emulib_rammodel_addr_arb: the IDLE/BUSY round-robin address-channel FSM plus mux, instantiated twice (AW with a `can_grant` = !full input, AR with can_grant tied to 1).
- The WFIFO is a small inline register array.

Test Plan:
1. Reset, then idle: all valid/ready outputs 0 for 10 cycles; first solo s1 AW (addr 0x100, id 3, len 0) appears on m_axi with awid 0x13 exactly one cycle after s1_awvalid rises.
2. s0 and s1 assert AW in the same cycle:
   - grant order is s0, s1, s0, s1 across 4 back-to-back requests each;
   - m_awid MSB alternates 0,1,0,1.
3. s0 AW (len 3), then s1 AW (len 1); s1 drives W first:
   - s1_wready stays 0 until s0's 4 beats complete with wlast;
   - s1's 2 beats then pass;
   - the memory readback shows both bursts intact.
4. WFIFO full: 4 AWs granted with m_wready=0:
   - a fifth s0_awvalid gets no grant (m_awvalid 0);
   - after one wlast pop, it is granted one cycle later.
5. Response routing:
   - m_rid 0x15 with rlast produces s1_rvalid with rid 5, s0_rvalid 0;
   - m_bid 0x02 produces s0_bvalid with bid 2.
6. rst asserted mid-burst (beat 2 of 4) with s0 also reset:
   - next cycle all valids/readies are 0, FIFO is empty, rr_aw = 0;
   - a fresh transfer completes correctly.
